// File: rtl/solitaire_pkg.sv
// solitaire_pkg: shared types and constants for the peg-solitaire move sequencer
package solitaire_pkg;
  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;
  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    dir_e       dir;
  } move_t;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CHECK
  } state_e;
  // (0,0) is a corner outside the cross-shaped board, so a parked move is never applied
  localparam logic [2:0] PARK_X   = 3'd0;
  localparam logic [2:0] PARK_Y   = 3'd0;
  localparam dir_e       PARK_DIR = DIR_LEFT;
  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return &v ? v : v + 6'd1;
  endfunction
endpackage

// File: rtl/solitaire_move_sequencer_if.sv
// solitaire_move_sequencer_if: upstream move handshake plus board-side bus
interface solitaire_move_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_x;
  logic [2:0] in_y;
  logic [1:0] in_dir;
  logic [2:0] piece_x;
  logic [2:0] piece_y;
  logic [1:0] direction;
  logic [5:0] piece_count;
  logic       game_over;
  modport master (
    input  in_valid, in_x, in_y, in_dir, piece_count, game_over,
    output in_ready, piece_x, piece_y, direction
  );
  modport slave (
    output in_valid, in_x, in_y, in_dir, piece_count, game_over,
    input  in_ready, piece_x, piece_y, direction
  );
endinterface

// File: rtl/move_fifo.sv
// move_fifo: synchronous FIFO; pointers carry an extra wrap bit to tell full from empty
module move_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    empty   = wr_q == rd_q;
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d    = do_pop ? rd_q + (AW+1)'(1) : rd_q;
    rdata   = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/solitaire_move_sequencer.sv
// solitaire_move_sequencer: buffers moves and issues them to the board one at a time,
// judging each by the piece_count drop seen the cycle after it was driven
module solitaire_move_sequencer
  import solitaire_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int BOARD_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  solitaire_move_sequencer_if.master bus,
  output logic                       move_ok,
  output logic                       move_rej,
  output logic [5:0]                 accepted_count,
  output logic                       busy,
  output logic                       finished
);
  localparam int COORD_W = $clog2(BOARD_WIDTH + 1);
  localparam int MOVE_W  = 2 * COORD_W + 2;
  localparam move_t PARK = '{x: PARK_X, y: PARK_Y, dir: PARK_DIR};
  state_e state_q, state_d;
  move_t piece_q, piece_d, head;
  logic [5:0] pre_count_q, pre_count_d, acc_q, acc_d;
  logic ok_q, ok_d, rej_q, rej_d, finished_q, finished_d;
  logic pop, full, empty, applied;
  logic [MOVE_W-1:0] fifo_rdata;
  move_fifo #(
    .WIDTH(MOVE_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (bus.in_valid),
    .pop  (pop),
    .wdata({bus.in_x, bus.in_y, bus.in_dir}),
    .rdata(fifo_rdata),
    .full (full),
    .empty(empty)
  );
  assign head = fifo_rdata;
  always_comb begin
    state_d     = state_q;
    piece_d     = PARK;
    pre_count_d = pre_count_q;
    acc_d       = acc_q;
    ok_d        = 1'b0;
    rej_d       = 1'b0;
    pop         = 1'b0;
    // a zero pre_count can never drop, so the subtraction is only trusted when nonzero
    applied     = (pre_count_q != 6'd0) && (bus.piece_count == pre_count_q - 6'd1);
    finished_d  = finished_q || (state_q == ST_IDLE && empty && bus.game_over);
    unique case (state_q)
      ST_IDLE: begin
        if (enable && !empty) begin
          pop         = 1'b1;
          piece_d     = head;
          pre_count_d = bus.piece_count;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_CHECK;
      ST_CHECK: begin
        ok_d    = applied;
        rej_d   = !applied;
        acc_d   = applied ? sat_inc(acc_q) : acc_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      piece_q     <= PARK;
      pre_count_q <= '0;
      acc_q       <= '0;
      ok_q        <= 1'b0;
      rej_q       <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      piece_q     <= piece_d;
      pre_count_q <= pre_count_d;
      acc_q       <= acc_d;
      ok_q        <= ok_d;
      rej_q       <= rej_d;
      finished_q  <= finished_d;
    end
  end
  assign bus.in_ready   = !full;
  assign bus.piece_x    = piece_q.x;
  assign bus.piece_y    = piece_q.y;
  assign bus.direction  = piece_q.dir;
  assign move_ok        = ok_q;
  assign move_rej       = rej_q;
  assign accepted_count = acc_q;
  assign busy           = (state_q != ST_IDLE) || !empty;
  assign finished       = finished_q;
endmodule

// File: doc/solitaire_move_sequencer.md
Name: solitaire_move_sequencer

Overview:
Initiator side of the peg-solitaire board move interface. Accepts move commands (x, y, direction) from an upstream valid/ready source and buffers them in a small FIFO. Each move is presented to the board for exactly one cycle, then the board output is parked on a non-existent square. The move is judged accepted or rejected by watching the board's piece_count on the following cycle.

Parameters:
FIFO_DEPTH, 4, move buffer entries; power of two, at least 2.
BOARD_WIDTH, 7, board edge length; coordinates are 3 bits.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
enable  input  1  1 = issue buffered moves; 0 = hold in IDLE, FIFO still accepts pushes
in_valid  input  1  upstream move valid
in_ready  output  1  FIFO not full
in_x  input  3  move source column
in_y  input  3  move source row
in_dir  input  2  direction: 00 LEFT, 01 RIGHT, 10 UP, 11 DOWN
piece_x  output  3  to board, registered
piece_y  output  3  to board, registered
direction  output  2  to board, registered
piece_count  input  6  from board
game_over  input  1  from board
move_ok  output  1  one-cycle pulse: last issued move was applied
move_rej  output  1  one-cycle pulse: last issued move was not applied
accepted_count  output  6  moves applied since reset, saturating at 63
busy  output  1  high when state != IDLE or FIFO not empty
finished  output  1  sticky: game_over seen high while IDLE with the FIFO empty

Behaviour:
- Reset values (synchronous, when rst_n=0 at posedge): piece_x=0, piece_y=0, direction=00, move_ok=0, move_rej=0, accepted_count=0, finished=0, FIFO empty, state IDLE.
- Park position is (0,0) with dir 00. That square does not exist, so the board never applies a move there. Outputs are parked in every state except ISSUE.
- FIFO:
  - Push when in_valid && in_ready; in_ready = !full, combinational from FIFO state.
  - Pop happens on the IDLE->ISSUE transition.
  - Push and pop in the same cycle are both honoured. A push while full is ignored (in_ready=0); no pass-through.
- FSM states: IDLE, ISSUE, CHECK.
  - IDLE: if enable && !empty, pop the head, load piece_x/y/direction with it, capture pre_count=piece_count, and go to ISSUE.
  - ISSUE (1 cycle): the move is driven to the board. The board commits it at the end of this cycle. Then load the park values and go to CHECK.
  - CHECK (1 cycle): if pre_count != 0 and piece_count == pre_count-1, pulse move_ok and increment accepted_count (saturating). Otherwise pulse move_rej. Then go to IDLE.
- Throughput: one move per 3 cycles (IDLE, ISSUE, CHECK). Pulses are registered and appear the cycle after CHECK.
- Moves are issued even when game_over=1; they will be reported as rejected.
- finished is set when state is IDLE, the FIFO is empty and game_over=1. It is cleared only by reset.
- enable dropped during ISSUE or CHECK: the move in flight completes; the FSM then holds in IDLE.
- Reset mid-ISSUE: outputs park the next cycle and the FIFO contents are discarded. The board is reset independently; no move is guaranteed.
- All arithmetic is unsigned 6-bit. pre_count-1 is evaluated only when pre_count != 0.

Decomposition:
- solitaire_pkg:
  - direction enum (LEFT/RIGHT/UP/DOWN)
  - move struct {x[2:0], y[2:0], dir[1:0]}
  - PARK_X, PARK_Y, PARK_DIR constants
  - FSM state enum
- Sub-module move_fifo:
  - Parameterised width/depth synchronous FIFO with push, pop, full, empty, head data.
  - Pointers carry one extra bit so full and empty can be told apart.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> piece_x/y=0, direction=00, in_ready=1, busy=0, accepted_count=0.
- Legal move: fresh board, push (x=3, y=1, DOWN) -> piece_x=3/y=1 for exactly one cycle; board piece_count 32->31; move_ok pulses once; accepted_count=1; outputs return to (0,0).
- Illegal move: after the previous test, push (3,1,DOWN) again -> piece_count stays 31, move_rej pulses, accepted_count stays 1.
- Buffering: enable=0, push 5 moves with FIFO_DEPTH=4 -> in_ready drops after the 4th push and the 5th is held off. Then enable=1 -> 4 moves issued 3 cycles apart in FIFO order.
- Simultaneous push/pop on a non-full FIFO -> no lost or duplicated moves. Checked by a scoreboard comparing issued moves against pushed moves.
- Mid-operation reset and game end: assert rst_n=0 during ISSUE -> parked next cycle, FIFO empty. Separately, drive game_over=1 with the FIFO empty -> finished=1 and stays set until reset.
